// File: rtl/conv_line_controller.sv
// conv_line_controller: streams each source line through a (2R+1)-tap window
// with border handling, and writes the external kernel result to a destination
// SRAM, optionally transposed.
module conv_line_controller #(
    parameter int unsigned DW   = 8,
    parameter int unsigned IDXW = 8,
    parameter int unsigned R    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IDXW-1:0]         nrows,
    input  logic [IDXW-1:0]         ncols,
    input  logic [1:0]              border_mode,
    input  logic                    transpose,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [IDXW-1:0]         src_row,
    output logic [IDXW-1:0]         src_col,
    input  logic [DW-1:0]           src_dout,
    output logic [(2*R+1)*DW-1:0]   win,
    input  logic [DW-1:0]           kern_res,
    output logic [IDXW-1:0]         dst_row,
    output logic [IDXW-1:0]         dst_col,
    output logic [DW-1:0]           dst_din,
    output logic                    dst_we
);

    localparam int unsigned NT   = 2 * R + 1;
    localparam int unsigned WINW = NT * DW;
    // Virtual column needs sign plus one headroom bit so ncols-1+R never wraps.
    localparam int unsigned VW   = IDXW + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_LINE  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] MODE_REPL = 2'd1;
    localparam logic [1:0] MODE_ZERO = 2'd2;

    localparam logic signed [VW-1:0] V_ZERO  = '0;
    localparam logic signed [VW-1:0] V_ONE   = VW'(1);
    localparam logic signed [VW-1:0] V_R     = VW'(R);
    localparam logic signed [VW-1:0] V_FIRST = V_ZERO - V_R;

    // FSM and loop counters
    logic [2:0]             state_q, state_d;
    logic signed [VW-1:0]   v_q, v_d;
    logic [IDXW-1:0]        line_q, line_d;
    logic                   drain_q, drain_d;
    logic                   cfg_err_q, cfg_err_d;

    // Job configuration captured on accepted start
    logic [IDXW-1:0]        nrows_q;
    logic [IDXW-1:0]        ncols_q;
    logic [1:0]             mode_q;
    logic                   tr_q;

    // Derived bounds and address mapping
    logic signed [VW-1:0]   ncols_s;
    logic signed [VW-1:0]   last_s;
    logic signed [VW-1:0]   v_last;
    logic signed [VW-1:0]   refl_v;
    logic                   cfg_bad;
    logic                   lo, hi;
    logic [IDXW-1:0]        map_col;
    logic                   map_zero;
    logic                   map_wr;
    logic [IDXW-1:0]        map_c;

    // Read issue stage (address on the SRAM this cycle)
    logic                   iss_vld_q;
    logic                   iss_zero_q;
    logic                   iss_wr_q;
    logic [IDXW-1:0]        iss_c_q;
    logic [IDXW-1:0]        src_row_q;
    logic [IDXW-1:0]        src_col_q;

    // Data return stage (src_dout valid this cycle)
    logic                   rd_vld_q;
    logic                   rd_zero_q;
    logic                   rd_wr_q;
    logic [IDXW-1:0]        rd_c_q;

    // Window and write port
    logic [WINW-1:0]        win_q;
    logic [DW-1:0]          shift_in;
    logic                   dst_we_q;
    logic [IDXW-1:0]        dst_row_q;
    logic [IDXW-1:0]        dst_col_q;

    // Status outputs
    logic                   busy_q;
    logic                   done_q;

    assign ncols_s = $signed({2'b00, ncols_q});
    assign last_s  = ncols_s - V_ONE;
    assign v_last  = last_s + V_R;
    assign cfg_bad = (nrows_q == '0) || (ncols_q == '0) || (ncols_q < IDXW'(R + 1));

    // State register and loop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            v_q       <= '0;
            line_q    <= '0;
            drain_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            line_q    <= line_d;
            drain_q   <= drain_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic: line sweep over v = -R .. ncols-1+R, then two drain cycles
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        line_d    = line_q;
        drain_d   = drain_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CHECK;
                    cfg_err_d = 1'b0;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    state_d   = S_FIN;
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = S_LINE;
                    line_d  = '0;
                    v_d     = V_FIRST;
                end
            end
            S_LINE: begin
                if (v_q == v_last) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    v_d = v_q + V_ONE;
                end
            end
            S_DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else if (line_q == nrows_q - IDXW'(1)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_LINE;
                    line_d  = line_q + IDXW'(1);
                    v_d     = V_FIRST;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Map the next virtual column onto a physical column plus zero/write tags
    always_comb begin
        lo       = v_d[VW-1];
        hi       = (v_d > last_s);
        refl_v   = lo ? (V_ZERO - v_d) : (last_s + last_s - v_d);
        map_col  = IDXW'(v_d);
        map_zero = 1'b0;
        map_wr   = (v_d >= V_R);
        map_c    = IDXW'(v_d - V_R);
        if (lo || hi) begin
            case (mode_q)
                MODE_REPL: map_col = lo ? '0 : (ncols_q - IDXW'(1));
                MODE_ZERO: begin
                    map_col  = '0;
                    map_zero = 1'b1;
                end
                default:   map_col = IDXW'(refl_v);
            endcase
        end
    end

    // Zero-border taps replace the returned pixel with 0
    always_comb begin
        shift_in = src_dout;
        if (rd_zero_q) begin
            shift_in = '0;
        end
    end

    // Configuration capture, read pipeline, window shift and write port
    always_ff @(posedge clk) begin
        if (rst) begin
            nrows_q    <= '0;
            ncols_q    <= '0;
            mode_q     <= '0;
            tr_q       <= 1'b0;
            iss_vld_q  <= 1'b0;
            iss_zero_q <= 1'b0;
            iss_wr_q   <= 1'b0;
            iss_c_q    <= '0;
            src_row_q  <= '0;
            src_col_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_zero_q  <= 1'b0;
            rd_wr_q    <= 1'b0;
            rd_c_q     <= '0;
            win_q      <= '0;
            dst_we_q   <= 1'b0;
            dst_row_q  <= '0;
            dst_col_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                nrows_q <= nrows;
                ncols_q <= ncols;
                mode_q  <= (border_mode == 2'd3) ? 2'd0 : border_mode;
                tr_q    <= transpose;
            end

            iss_vld_q <= (state_d == S_LINE);
            if (state_d == S_LINE) begin
                src_row_q  <= line_d;
                src_col_q  <= map_col;
                iss_zero_q <= map_zero;
                iss_wr_q   <= map_wr;
                iss_c_q    <= map_c;
            end

            rd_vld_q  <= iss_vld_q;
            rd_zero_q <= iss_zero_q;
            rd_wr_q   <= iss_wr_q;
            rd_c_q    <= iss_c_q;

            if (rd_vld_q) begin
                win_q <= {shift_in, win_q[WINW-1:DW]};
            end else if (state_q == S_DRAIN && drain_q) begin
                win_q <= '0;
            end

            // Window holding columns c-R..c+R becomes visible with this write
            dst_we_q <= rd_vld_q && rd_wr_q;
            if (rd_vld_q && rd_wr_q) begin
                dst_row_q <= tr_q ? rd_c_q : line_q;
                dst_col_q <= tr_q ? line_q : rd_c_q;
            end
        end
    end

    // Status flags follow the next state so they align with CHECK and FIN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == S_CHECK) || (state_d == S_LINE) || (state_d == S_DRAIN);
            done_q <= (state_d == S_FIN);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign src_row = src_row_q;
    assign src_col = src_col_q;
    assign win     = win_q;
    assign dst_row = dst_row_q;
    assign dst_col = dst_col_q;
    assign dst_din = kern_res;
    assign dst_we  = dst_we_q;

endmodule

// File: tb/tb_conv_line_controller.sv
// Directed testbench for conv_line_controller (DW=8, IDXW=8, R=5).
module tb_conv_line_controller;

    localparam int unsigned DW   = 8;
    localparam int unsigned IDXW = 8;
    localparam int unsigned R    = 5;
    localparam int unsigned NT   = 2 * R + 1;

    typedef logic [127:0] val_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [IDXW-1:0]      nrows;
    logic [IDXW-1:0]      ncols;
    logic [1:0]           border_mode;
    logic                 transpose;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    logic [IDXW-1:0]      src_row;
    logic [IDXW-1:0]      src_col;
    logic [DW-1:0]        src_dout;
    logic [NT*DW-1:0]     win;
    logic [DW-1:0]        kern_res;
    logic [IDXW-1:0]      dst_row;
    logic [IDXW-1:0]      dst_col;
    logic [DW-1:0]        dst_din;
    logic                 dst_we;

    int nchk = 0;
    int nerr = 0;
    int gen  = 0;
    int nwr  = 0;

    logic [DW-1:0]    dmem [0:15][0:15];
    int               dgen [0:15][0:15];
    logic [NT*DW-1:0] wq [$];
    int               colq [$];

    int seq_refl[16]  = '{5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
    int w_refl_f[NT]  = '{5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5};
    int w_refl_l[NT]  = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
    int w_repl_f[NT]  = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5};
    int w_repl_l[NT]  = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 5};
    int w_zero_f[NT]  = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5};
    int w_zero_l[NT]  = '{0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0};

    conv_line_controller #(.DW(DW), .IDXW(IDXW), .R(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .nrows       (nrows),
        .ncols       (ncols),
        .border_mode (border_mode),
        .transpose   (transpose),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .src_row     (src_row),
        .src_col     (src_col),
        .src_dout    (src_dout),
        .win         (win),
        .kern_res    (kern_res),
        .dst_row     (dst_row),
        .dst_col     (dst_col),
        .dst_din     (dst_din),
        .dst_we      (dst_we)
    );

    always #5 clk = ~clk;

    // Image pixel: high nibble row, low nibble column
    function automatic logic [DW-1:0] pix(input logic [IDXW-1:0] r, input logic [IDXW-1:0] c);
        return {r[3:0], c[3:0]};
    endfunction

    function automatic logic [NT*DW-1:0] pack(input int t[NT]);
        logic [NT*DW-1:0] w;
        w = '0;
        for (int k = 0; k < NT; k++) w[k*DW +: DW] = DW'(t[k]);
        return w;
    endfunction

    // Kernel stand-in: pass the centre tap
    assign kern_res = win[R*DW +: DW];

    // Source SRAM: one-cycle read latency
    always @(posedge clk) src_dout <= pix(src_row, src_col);

    // Destination SRAM and write log
    always @(posedge clk) begin
        if (dst_we) begin
            nwr <= nwr + 1;
            wq.push_back(win);
            colq.push_back(int'(dst_col));
            if (dst_row < 16 && dst_col < 16) begin
                dmem[dst_row][dst_col] <= dst_din;
                dgen[dst_row][dst_col] <= gen;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input val_t obs, input val_t exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int nr, input int nc, input logic [1:0] bm, input logic tr);
        nrows       = IDXW'(nr);
        ncols       = IDXW'(nc);
        border_mode = bm;
        transpose   = tr;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        int base_w;
        int base_q;
        int nw0;

        rst = 1'b1; start = 1'b0; nrows = '0; ncols = '0; border_mode = '0; transpose = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                dmem[i][j] = '0;
                dgen[i][j] = -1;
            end
        end
        tick(); tick(); tick();

        // Reset state
        chk("rst_busy", val_t'(busy), val_t'(0));
        chk("rst_done", val_t'(done), val_t'(0));
        chk("rst_cfg_err", val_t'(cfg_err), val_t'(0));
        chk("rst_dst_we", val_t'(dst_we), val_t'(0));
        chk("rst_win", val_t'(win), val_t'(0));
        chk("rst_src_col", val_t'(src_col), val_t'(0));
        rst = 1'b0;
        tick();

        // Reflect, 1x6 ramp
        gen = 1; base_w = nwr; base_q = wq.size();
        go(1, 6, 2'd0, 1'b0);
        chk("refl_busy_check", val_t'(busy), val_t'(1));
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("refl_src_col%0d", i), val_t'(src_col), val_t'(seq_refl[i-1]));
        end
        tick(); tick();
        chk("refl_done_early", val_t'(done), val_t'(0));
        tick();
        chk("refl_done", val_t'(done), val_t'(1));
        chk("refl_busy_fin", val_t'(busy), val_t'(0));
        chk("refl_nwr", val_t'(nwr - base_w), val_t'(6));
        chk("refl_win_first", val_t'(wq[base_q]), val_t'(pack(w_refl_f)));
        chk("refl_win_last", val_t'(wq[base_q+5]), val_t'(pack(w_refl_l)));
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("refl_dst_col%0d", c), val_t'(colq[base_q+c]), val_t'(c));
            chk($sformatf("refl_dst%0d", c), val_t'({dgen[0][c], dmem[0][c]}), val_t'({gen, pix(0, IDXW'(c))}));
        end
        tick();

        // Replicate
        base_w = nwr; base_q = wq.size();
        go(1, 6, 2'd1, 1'b0);
        for (int i = 1; i <= 19; i++) tick();
        chk("repl_done", val_t'(done), val_t'(1));
        chk("repl_nwr", val_t'(nwr - base_w), val_t'(6));
        chk("repl_win_first", val_t'(wq[base_q]), val_t'(pack(w_repl_f)));
        chk("repl_win_last", val_t'(wq[base_q+5]), val_t'(pack(w_repl_l)));
        tick();

        // Zero border
        base_w = nwr; base_q = wq.size();
        go(1, 6, 2'd2, 1'b0);
        for (int i = 1; i <= 19; i++) tick();
        chk("zero_done", val_t'(done), val_t'(1));
        chk("zero_nwr", val_t'(nwr - base_w), val_t'(6));
        chk("zero_win_first", val_t'(wq[base_q]), val_t'(pack(w_zero_f)));
        chk("zero_win_last", val_t'(wq[base_q+5]), val_t'(pack(w_zero_l)));
        tick();

        // Rejected: ncols below R+1
        base_w = nwr;
        go(1, 4, 2'd0, 1'b0);
        chk("err4_done_check", val_t'(done), val_t'(0));
        tick();
        chk("err4_done", val_t'(done), val_t'(1));
        chk("err4_cfg_err", val_t'(cfg_err), val_t'(1));
        chk("err4_busy", val_t'(busy), val_t'(0));
        tick();
        chk("err4_done_pulse", val_t'(done), val_t'(0));
        chk("err4_cfg_hold", val_t'(cfg_err), val_t'(1));
        chk("err4_nwr", val_t'(nwr - base_w), val_t'(0));

        // Rejected: nrows zero
        go(0, 8, 2'd0, 1'b0);
        tick();
        chk("err0_done", val_t'(done), val_t'(1));
        chk("err0_cfg_err", val_t'(cfg_err), val_t'(1));
        tick();
        chk("err0_nwr", val_t'(nwr - base_w), val_t'(0));

        // Transposed 3x8 job; stray start and config churn while busy
        gen = 2; base_w = nwr;
        go(3, 8, 2'd0, 1'b1);
        chk("tr_cfg_err_clr", val_t'(cfg_err), val_t'(0));
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 5) begin
                start = 1'b1; nrows = 8'd1; ncols = 8'd6; transpose = 1'b0; border_mode = 2'd2;
            end
            if (i == 6) start = 1'b0;
        end
        chk("tr_done_early", val_t'(done), val_t'(0));
        tick();
        chk("tr_done", val_t'(done), val_t'(1));
        chk("tr_nwr", val_t'(nwr - base_w), val_t'(24));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("tr_dst_r%0d_c%0d", r, c), val_t'({dgen[c][r], dmem[c][r]}),
                    val_t'({gen, pix(IDXW'(r), IDXW'(c))}));
            end
        end
        for (int i = 0; i < 5; i++) tick();
        chk("tr_no_second_busy", val_t'(busy), val_t'(0));
        chk("tr_no_second_nwr", val_t'(nwr - base_w), val_t'(24));

        // Reset in the middle of line 1
        gen = 3;
        go(3, 8, 2'd0, 1'b0);
        for (int i = 1; i <= 35; i++) tick();
        chk("mid_we", val_t'(dst_we), val_t'(1));
        rst = 1'b1;
        tick();
        chk("abort_we", val_t'(dst_we), val_t'(0));
        chk("abort_busy", val_t'(busy), val_t'(0));
        chk("abort_win", val_t'(win), val_t'(0));
        rst = 1'b0;
        nw0 = nwr;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_nwr", val_t'(nwr - nw0), val_t'(0));

        // Full rerun after abort
        gen = 4; base_w = nwr;
        go(3, 8, 2'd0, 1'b0);
        for (int i = 1; i <= 61; i++) tick();
        chk("rerun_done", val_t'(done), val_t'(1));
        chk("rerun_nwr", val_t'(nwr - base_w), val_t'(24));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("rerun_dst_r%0d_c%0d", r, c), val_t'({dgen[r][c], dmem[r][c]}),
                    val_t'({gen, pix(IDXW'(r), IDXW'(c))}));
            end
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
